// File: rtl/fpu_ss_pkg.sv
// Shared types and widths for the FPU subsystem writeback path.
package fpu_ss_pkg;

    localparam int unsigned WB_RD_WIDTH     = 5;
    localparam int unsigned WB_DATA_WIDTH   = 32;
    // Widest instruction ID carried by a buffered entry; narrower IDs are zero-extended.
    localparam int unsigned WB_ID_MAX_WIDTH = 16;

    typedef struct packed {
        logic [WB_ID_MAX_WIDTH-1:0] id;
        logic [WB_RD_WIDTH-1:0]     rd;
        logic [WB_DATA_WIDTH-1:0]   data;
        logic                       we;
    } wb_entry_t;

endpackage

// File: rtl/fpu_ss_csr_fifo.sv
// Small FIFO of writeback entries for CSR completions; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module fpu_ss_csr_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_c,
    output logic [CNT_W-1:0] count_o,
    output logic             full_c,
    output logic             empty_c
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_o == CNT_W'(DEPTH));
    assign empty_c = (count_o == '0);
    assign pop_ok  = pop_i && !empty_c;
    assign push_ok = push_i && (!full_c || pop_ok);
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/fpu_ss_wb_arb.sv
// Writeback arbiter merging CSR completions and FPU results into one registered
// result slot. Optional macro FPU_SS_WB_CSR_BYPASS_EN lets a CSR completion skip an empty FIFO.
module fpu_ss_wb_arb
    import fpu_ss_pkg::*;
#(
    parameter int unsigned CSR_BUF_DEPTH = 4,
    parameter int unsigned ID_WIDTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     csr_instr_i,
    input  logic                     csr_wb_i,
    input  logic [WB_RD_WIDTH-1:0]   csr_wb_addr_i,
    input  logic [ID_WIDTH-1:0]      csr_wb_id_i,
    input  logic [WB_DATA_WIDTH-1:0] csr_rdata_i,
    output logic                     csr_buf_full_o,
    output logic                     csr_overflow_o,
    input  logic                     fpu_out_valid_i,
    output logic                     fpu_out_ready_o,
    input  logic [WB_DATA_WIDTH-1:0] fpu_result_i,
    input  logic [WB_RD_WIDTH-1:0]   fpu_rd_i,
    input  logic [ID_WIDTH-1:0]      fpu_id_i,
    input  logic                     fpu_we_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_WIDTH-1:0]      result_id_o,
    output logic [WB_RD_WIDTH-1:0]   result_rd_o,
    output logic [WB_DATA_WIDTH-1:0] result_data_o,
    output logic                     result_we_o
);

    localparam int unsigned CNT_W = $clog2(CSR_BUF_DEPTH) + 1;

    wb_entry_t        csr_entry;
    wb_entry_t        fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             load_en;
    logic             bypass;
    logic             overflow_set;
    logic             unused_head_id_hi;

    // A completion without writeback still carries its ID, but never data.
    always_comb begin
        csr_entry      = '0;
        csr_entry.id   = WB_ID_MAX_WIDTH'(csr_wb_id_i);
        csr_entry.rd   = csr_wb_addr_i;
        csr_entry.data = csr_wb_i ? csr_rdata_i : '0;
        csr_entry.we   = csr_wb_i;
    end

    assign load_en = !result_valid_o || result_ready_i;

`ifdef FPU_SS_WB_CSR_BYPASS_EN
    assign bypass = csr_instr_i && fifo_empty && load_en;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_pop        = load_en && !fifo_empty;
    assign fifo_push       = csr_instr_i && !bypass;
    assign overflow_set    = fifo_push && fifo_full && !fifo_pop;
    assign fpu_out_ready_o = load_en && fifo_empty && !bypass;
    // One spare slot absorbs the completion already in flight after an upstream pop.
    assign csr_buf_full_o  = (fifo_count >= CNT_W'(CSR_BUF_DEPTH - 1));

    assign unused_head_id_hi = |(fifo_head.id >> ID_WIDTH);

    fpu_ss_csr_fifo #(
        .DEPTH (CSR_BUF_DEPTH)
    ) u_csr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .entry_i (csr_entry),
        .pop_i   (fifo_pop),
        .head_c  (fifo_head),
        .count_o (fifo_count),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    // Output slot: CSR FIFO head has priority over the FPU result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
            result_we_o    <= 1'b0;
            csr_overflow_o <= 1'b0;
        end else begin
            if (overflow_set) csr_overflow_o <= 1'b1;
            if (load_en) begin
                if (!fifo_empty) begin
                    result_valid_o <= 1'b1;
                    result_id_o    <= ID_WIDTH'(fifo_head.id);
                    result_rd_o    <= fifo_head.rd;
                    result_data_o  <= fifo_head.data;
                    result_we_o    <= fifo_head.we;
                end else if (bypass) begin
                    result_valid_o <= 1'b1;
                    result_id_o    <= csr_wb_id_i;
                    result_rd_o    <= csr_entry.rd;
                    result_data_o  <= csr_entry.data;
                    result_we_o    <= csr_entry.we;
                end else if (fpu_out_valid_i) begin
                    result_valid_o <= 1'b1;
                    result_id_o    <= fpu_id_i;
                    result_rd_o    <= fpu_rd_i;
                    result_data_o  <= fpu_result_i;
                    result_we_o    <= fpu_we_i;
                end else begin
                    result_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_ss_wb_arb.sv
// Self-checking bench for fpu_ss_wb_arb: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_fpu_ss_wb_arb;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDW   = 4;
`ifdef FPU_SS_WB_CSR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [41:0] ent_t;  // {id, rd, data, we}

    logic           clk = 1'b0;
    logic           rst_n;
    logic           csr_instr, csr_wb, fpu_valid, fpu_we, res_ready;
    logic [4:0]     csr_rd, fpu_rd;
    logic [IDW-1:0] csr_id, fpu_id;
    logic [31:0]    csr_data, fpu_data;
    logic           buf_full, ovf, fpu_ready, res_valid, res_we;
    logic [IDW-1:0] res_id;
    logic [4:0]     res_rd;
    logic [31:0]    res_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];
    logic m_v;
    ent_t m_slot;
    logic m_ovf;
    logic fpu_taken;

    fpu_ss_wb_arb #(.CSR_BUF_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_instr_i(csr_instr), .csr_wb_i(csr_wb), .csr_wb_addr_i(csr_rd),
        .csr_wb_id_i(csr_id), .csr_rdata_i(csr_data),
        .csr_buf_full_o(buf_full), .csr_overflow_o(ovf),
        .fpu_out_valid_i(fpu_valid), .fpu_out_ready_o(fpu_ready),
        .fpu_result_i(fpu_data), .fpu_rd_i(fpu_rd), .fpu_id_i(fpu_id), .fpu_we_i(fpu_we),
        .result_valid_o(res_valid), .result_ready_i(res_ready),
        .result_id_o(res_id), .result_rd_o(res_rd), .result_data_o(res_data), .result_we_o(res_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        csr_instr = 0; csr_wb = 0; csr_rd = '0; csr_id = '0; csr_data = '0;
        fpu_valid = 0; fpu_we = 0; fpu_rd = '0; fpu_id = '0; fpu_data = '0;
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic step();
        logic load, byp;
        ent_t ce;
        @(negedge clk);
        load = !m_v || res_ready;
        byp  = BYP && csr_instr && (q.size() == 0) && load;
        check("valid", 64'(res_valid), 64'(m_v));
        if (m_v) check("payload", 64'({res_id, res_rd, res_data, res_we}), 64'(m_slot));
        check("fpu_ready", 64'(fpu_ready), 64'(load && q.size() == 0 && !byp));
        check("buf_full", 64'(buf_full), 64'(q.size() >= DEPTH - 1));
        check("overflow", 64'(ovf), 64'(m_ovf));
        fpu_taken = fpu_valid && load && q.size() == 0 && !byp;
        ce = {csr_id, csr_rd, (csr_wb ? csr_data : 32'h0), csr_wb};
        @(posedge clk);
        if (load) begin
            if (q.size() > 0) begin
                m_slot = q.pop_front(); m_v = 1'b1;
            end else if (byp) begin
                m_slot = ce; m_v = 1'b1;
            end else if (fpu_valid) begin
                m_slot = {fpu_id, fpu_rd, fpu_data, fpu_we}; m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
        end
        if (csr_instr && !byp) begin
            if (q.size() < DEPTH) q.push_back(ce);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        q.delete(); m_v = 0; m_slot = '0; m_ovf = 0;
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_payload", 64'({res_id, res_rd, res_data, res_we}), 64'(0));
        check("rst_full", 64'(buf_full), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
    endtask

    task automatic csr_push(input logic [IDW-1:0] id, input logic wb, input logic [4:0] rd,
                            input logic [31:0] d);
        csr_instr = 1; csr_wb = wb; csr_id = id; csr_rd = rd; csr_data = d;
        step();
        csr_instr = 0;
    endtask

    initial begin
        logic seen;
        logic [IDW-1:0] exp_id;
        rst_n = 1; res_ready = 1; idle();
        q.delete(); m_v = 0; m_slot = '0; m_ovf = 0; fpu_taken = 0;
        do_reset();

        // CSR read latency
        csr_push(4'd3, 1'b1, 5'd10, 32'h40);
        check("csr_rd_n1", 64'(res_valid), 64'(BYP));
        step();
        check("csr_rd_n2", 64'(res_valid), 64'(!BYP));
        if (res_valid) check("csr_rd_data", 64'({res_id, res_rd, res_data, res_we}),
                             64'({4'd3, 5'd10, 32'h40, 1'b1}));
        step(); step();

        // CSR completion without writeback
        csr_push(4'd5, 1'b0, 5'd7, 32'hDEAD_BEEF);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid && res_id == 4'd5) begin
                seen = 1;
                check("csr_nowb", 64'({res_we, res_data}), 64'(0));
            end
            step();
        end
        check("csr_nowb_seen", 64'(seen), 64'(1));

        // FPU offered while a CSR entry is pending: CSR goes first
        res_ready = 0;
        csr_push(4'd9, 1'b1, 5'd1, 32'h1234);
        csr_push(4'd1, 1'b1, 5'd2, 32'h5678);
        fpu_valid = 1; fpu_id = 4'd2; fpu_rd = 5'd3; fpu_data = 32'hCAFE; fpu_we = 1;
        res_ready = 1;
        for (int i = 0; i < 6 && fpu_valid; i++) begin
            step();
            if (fpu_taken) fpu_valid = 0;
        end
        check("fpu_taken", 64'(fpu_valid), 64'(0));
        check("sim_order", 64'(res_id), 64'(2));
        step(); step();

        // Backpressure: slot holds one entry, FIFO fills behind it
        res_ready = 0;
        for (int i = 0; i < 4; i++) csr_push(IDW'(i + 4), 1'b1, 5'(i), 32'(i * 3));
        check("bp_full", 64'(buf_full), 64'(1));
        step(); step();
        res_ready = 1;
        exp_id = 4'd4;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) begin
                check("bp_order", 64'(res_id), 64'(exp_id));
                exp_id = exp_id + 4'd1;
            end
            step();
        end
        check("bp_count", 64'(exp_id), 64'(8));

        // Overflow: slot + 4 buffered, 6th push dropped
        res_ready = 0;
        for (int i = 0; i < 6; i++) csr_push(IDW'(i + 10), 1'b1, 5'd4, 32'(i));
        check("ovf_set", 64'(ovf), 64'(1));
        res_ready = 1;
        for (int i = 0; i < 7; i++) step();
        check("ovf_sticky", 64'(ovf), 64'(1));

        // Mid-stream reset with a valid slot and two buffered entries
        res_ready = 0;
        for (int i = 0; i < 3; i++) csr_push(IDW'(i + 1), 1'b1, 5'd6, 32'(i + 100));
        do_reset();
        res_ready = 1;
        for (int i = 0; i < 4; i++) step();

        // Random traffic; FPU holds its offer until accepted
        for (int i = 0; i < 3000; i++) begin
            res_ready = ($urandom_range(0, 9) < 7);
            if (!fpu_valid || fpu_taken) begin
                fpu_valid = ($urandom_range(0, 2) == 0);
                fpu_id = IDW'($urandom); fpu_rd = 5'($urandom);
                fpu_data = $urandom; fpu_we = 1'($urandom);
            end
            csr_instr = ($urandom_range(0, 2) == 0) && (i > 2000 || q.size() < DEPTH - 1);
            csr_wb = 1'($urandom); csr_id = IDW'($urandom); csr_rd = 5'($urandom);
            csr_data = $urandom;
            step();
        end
        idle();
        for (int i = 0; i < 10; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_ss_wb_arb.md
# fpu_ss_wb_arb

Result writeback arbiter for the FPU subsystem. Sits directly downstream of the floating-point CSR stage and the FPU result output. Merges CSR completions (read data, or a no-writeback completion) and FPU results into a single registered result channel towards the core, with valid/ready handshaking. CSR completions are buffered in a small FIFO because the CSR stage cannot be stalled once it has issued.

## Interface

Reset is synchronous and active-low; one clock.

**Parameters**
- `CSR_BUF_DEPTH`, default 4: CSR FIFO entries; power of two, at least 2.
- `ID_WIDTH`, default 4: instruction ID width.

**Ports**
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset.
- `csr_instr_i` in 1: CSR stage completes one CSR instruction this cycle (single-cycle pulse).
- `csr_wb_i` in 1: that CSR instruction writes the integer rd.
- `csr_wb_addr_i` in 5: rd index.
- `csr_wb_id_i` in ID_WIDTH: instruction ID.
- `csr_rdata_i` in 32: CSR read data.
- `csr_buf_full_o` out 1: upstream must not pop a new instruction into the CSR stage.
- `csr_overflow_o` out 1: sticky flag; a push was dropped.
- `fpu_out_valid_i` in 1: FPU result valid.
- `fpu_out_ready_o` out 1: arbiter accepts the FPU result.
- `fpu_result_i` in 32: FPU result data.
- `fpu_rd_i` in 5: FPU destination index.
- `fpu_id_i` in ID_WIDTH: FPU instruction ID.
- `fpu_we_i` in 1: result targets the integer register file.
- `result_valid_o` out 1: result channel valid.
- `result_ready_i` in 1: core accepts the result.
- `result_id_o` out ID_WIDTH, `result_rd_o` out 5, `result_data_o` out 32, `result_we_o` out 1: result payload.

## Operation

**CSR FIFO**
- On `csr_instr_i`=1, push the entry {id, rd, data, we = `csr_wb_i`}.
- A completion with `csr_wb_i`=0 still pushes an entry: the data field is 0, `we` is 0, and the entry exists only as a completion.
- A push while count==CSR_BUF_DEPTH is dropped and sets `csr_overflow_o`. The flag clears only on reset.
- `csr_buf_full_o` = (count >= CSR_BUF_DEPTH-1), computed from the registered count. The one spare slot absorbs the push already in flight, which arrives one cycle after an upstream pop.
- Simultaneous push and pop: count is unchanged, including when the FIFO is full.

**Output slot**
- The output slot is a single register holding `result_*`.
- `load_en` = !`result_valid_o` || `result_ready_i`.
- When `load_en`=1, the next content is chosen by fixed priority:
  - CSR FIFO head if the FIFO is non-empty (pop it);
  - else the FPU result if `fpu_out_valid_i`=1;
  - else the slot becomes invalid.
- `fpu_out_ready_o` = `load_en` && FIFO empty. This is combinational from `result_ready_i`.
- The core reorders results by ID, so the CSR-before-FPU priority carries no ordering obligation.
- Payload is held stable while `result_valid_o`=1 and `result_ready_i`=0.

**Reset**
- All outputs reset to 0: `result_valid_o`, `result_id_o`, `result_rd_o`, `result_data_o`, `result_we_o`, `csr_overflow_o`, `csr_buf_full_o`.
- FIFO pointers and count reset to 0.
- Reset mid-operation discards all buffered and in-slot results; nothing is emitted afterwards.

## Timing
- CSR path: `csr_instr_i` at cycle N → FIFO non-empty at N+1 → `result_valid_o` at N+2, provided the slot is free.
- FPU path: handshake at N → `result_valid_o` at N+1.
- Back-to-back throughput: one result per cycle while `result_ready_i`=1.
- FIFO pointers wrap modulo CSR_BUF_DEPTH. Count width is $clog2(CSR_BUF_DEPTH)+1.

## Configuration
- Macro `FPU_SS_WB_CSR_BYPASS_EN`.
- Defined: when `csr_instr_i`=1, the FIFO is empty and `load_en`=1, the CSR entry loads directly into the output slot with no push. CSR latency becomes N+1, and the FPU is not accepted that cycle (`fpu_out_ready_o`=0).
- Undefined: every CSR entry passes through the FIFO, with latency N+2.

## Structure
- Package `fpu_ss_pkg` holds:
  - typedef `wb_entry_t` {id, rd, data, we};
  - constant `WB_RD_WIDTH`=5.
- Sub-module `fpu_ss_csr_fifo`: a parameterised FIFO of `wb_entry_t` with push, pop, count, full and empty.
- Arbitration and the output register live in `fpu_ss_wb_arb`.

## Test plan
- **CSR read.** Single `csr_instr_i` with wb=1, rd=10, id=3, data=0x00000040, `result_ready_i`=1 → `result_valid_o` at N+2 with id=3, rd=10, data=0x40, we=1. With bypass enabled it appears at N+1.
- **CSR completion without writeback.** `csr_instr_i` with wb=0, id=5 → one result with id=5, we=0, data=0.
- **Simultaneous sources.** CSR (id=1) and FPU (id=2) valid in the same cycle → id=1 emitted first. `fpu_out_ready_o`=0 until the FIFO drains; id=2 follows on the next cycle.
- **Backpressure.** `result_ready_i`=0 for 6 cycles with DEPTH=4 and 4 CSR pushes:
  - `csr_buf_full_o` rises when count reaches 3;
  - the payload stays stable throughout;
  - after ready, ids emerge in push order.
- **Overflow.** 5th push while count=4 → `csr_overflow_o`=1, entry lost, the other 4 emitted intact.
- **Mid-stream reset.** `rst_ni`=0 for one cycle with 2 buffered entries and a valid slot → next cycle `result_valid_o`=0, FIFO empty, `csr_overflow_o`=0.
